// File: rtl/mdu_iter_if.sv
// Request/result bundle between the control unit and the iterative MUL/DIV unit.
// Latency: n/a (wires only).
// Backpressure: none; busy tells the master when start will be ignored.
//
// Signals:
//   start/op/a/b/rd_in : request, driven by the control unit (master)
//   busy/done          : status back to the control unit
//   wr_en/wr_rd/wr_data: register-file write port, driven by the unit (slave)
interface mdu_iter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [2:0]            rd_in;
    logic                  busy;
    logic                  done;
    logic                  wr_en;
    logic [2:0]            wr_rd;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output start, op, a, b, rd_in,
        input  busy, done, wr_en, wr_rd, wr_data
    );

    modport slave (
        input  start, op, a, b, rd_in,
        output busy, done, wr_en, wr_rd, wr_data
    );
endinterface

// File: rtl/mdu_iter.sv
// Radix-2 unsigned multiply/divide unit, one result bit per cycle, single issue.
// Latency: DATA_WIDTH+2 edges from start acceptance back to IDLE; divide-by-zero
// and disabled-divider ops take 2 edges. Backpressure: start ignored while busy.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, overrides everything (in-flight op dropped)
//   bus  - mdu_iter_if.slave: start/op/a/b/rd_in request, busy/done status,
//          wr_en/wr_rd/wr_data register-file write port
// Build option: define MDU_DIV_EN to include the restoring divider (DIVU/REMU).
// Without it DIVU/REMU complete immediately with a zero result.
module mdu_iter #(
    parameter int DATA_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    mdu_iter_if.slave   bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [1:0]              op_q, op_d;
    logic [2:0]              rd_q, rd_d;
    logic [DATA_WIDTH-1:0]   opa_q, opa_d;      // multiplicand
    logic [DATA_WIDTH-1:0]   opb_q, opb_d;      // multiplier (shifted out LSB first) or divisor
    logic [2*DATA_WIDTH-1:0] acc_q, acc_d;
    logic                    done_q, done_d;
    logic                    wr_en_q, wr_en_d;
    logic [2:0]              wr_rd_q, wr_rd_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;

    // ---------------- multiply step ----------------
    // Add the multiplicand into the high half with a carry bit, then shift
    // {carry, acc} right by one. After DATA_WIDTH steps acc holds the product.
    logic [DATA_WIDTH:0]     mul_sum;
    logic [2*DATA_WIDTH-1:0] mul_acc;

    assign mul_sum = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                   + {1'b0, (opb_q[0] ? opa_q : {DATA_WIDTH{1'b0}})};
    assign mul_acc = {mul_sum, acc_q[DATA_WIDTH-1:1]};

    // ---------------- divide step ----------------
    // acc = {remainder, quotient}; the quotient half starts out holding the
    // dividend and is shifted out into the remainder one bit per cycle.
`ifdef MDU_DIV_EN
    logic [DATA_WIDTH:0]     div_rem_sh;   // remainder after the left shift, one extra bit
    logic [DATA_WIDTH:0]     div_diff;
    logic [2*DATA_WIDTH-1:0] div_acc;

    assign div_rem_sh = acc_q[2*DATA_WIDTH-1:DATA_WIDTH-1];
    assign div_diff   = div_rem_sh - {1'b0, opb_q};
    // A set MSB in the difference is the borrow: restore the shifted remainder.
    assign div_acc    = div_diff[DATA_WIDTH]
                      ? {div_rem_sh[DATA_WIDTH-1:0], acc_q[DATA_WIDTH-2:0], 1'b0}
                      : {div_diff[DATA_WIDTH-1:0],   acc_q[DATA_WIDTH-2:0], 1'b1};
`endif

    logic [2*DATA_WIDTH-1:0] step_acc;

    always_comb begin
        step_acc = mul_acc;
`ifdef MDU_DIV_EN
        if (op_q[1]) begin
            step_acc = div_acc;
        end
`endif
    end

    // ---------------- control ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        wr_en_d   = 1'b0;
        wr_rd_d   = wr_rd_q;
        wr_data_d = wr_data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    rd_d    = bus.rd_in;
                    opa_d   = bus.a;
                    opb_d   = bus.b;
                    cnt_d   = CW'(DATA_WIDTH);
                    acc_d   = '0;
                    state_d = S_RUN;
                    if (bus.op[1]) begin
`ifdef MDU_DIV_EN
                        // Divider needs the dividend preloaded in the quotient half.
                        acc_d = {{DATA_WIDTH{1'b0}}, bus.a};
                        if (bus.b == '0) begin
                            // Divide by zero: quotient all ones, remainder = dividend.
                            state_d   = S_DONE;
                            done_d    = 1'b1;
                            wr_en_d   = (bus.rd_in != 3'd0);
                            wr_rd_d   = bus.rd_in;
                            wr_data_d = bus.op[0] ? bus.a : {DATA_WIDTH{1'b1}};
                        end
`else
                        state_d   = S_DONE;
                        done_d    = 1'b1;
                        wr_en_d   = (bus.rd_in != 3'd0);
                        wr_rd_d   = bus.rd_in;
                        wr_data_d = '0;
`endif
                    end
                end
            end

            S_RUN: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (!op_q[1]) begin
                    opb_d = opb_q >> 1;
                end
                if (cnt_q == CW'(1)) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    wr_en_d   = (rd_q != 3'd0);
                    wr_rd_d   = rd_q;
                    // op[0] picks the high half for both MULH (product high)
                    // and REMU (remainder); low half is MUL/DIVU.
                    wr_data_d = op_q[0] ? step_acc[2*DATA_WIDTH-1:DATA_WIDTH]
                                        : step_acc[DATA_WIDTH-1:0];
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            acc_q     <= '0;
            done_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_rd_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            done_q    <= done_d;
            wr_en_q   <= wr_en_d;
            wr_rd_q   <= wr_rd_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.busy    = (state_q != S_IDLE);
    assign bus.done    = done_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_rd   = wr_rd_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (DATA_WIDTH=8): vector table plus reset,
// back-to-back and divide-by-zero sequences. Expected values follow the build
// (MDU_DIV_EN defined or not).
module tb_mdu_iter;
    localparam int W = 8;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_iter_if #(.DATA_WIDTH(W)) bus ();
    mdu_iter #(.DATA_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string      nm;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] rd;
        logic [7:0] exp_data;
        int         exp_lat;   // edges, counting the accept edge, until done is visible
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string nm, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] rd,
                       input logic [7:0] exp_data, input int exp_lat);
        vec_t v;
        v.nm = nm; v.op = op; v.a = a; v.b = b; v.rd = rd;
        v.exp_data = exp_data; v.exp_lat = exp_lat;
        vecs.push_back(v);
    endtask

    // Issue one op, scramble the request inputs after acceptance, and check the
    // completion timing and write-port contents.
    task automatic run_op(input string nm, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [2:0] rd,
                          input logic [7:0] exp_data, input int exp_lat);
        int lat;
        bit seen;
        bit bad;
        int guard;
        guard = 0;
        while (bus.busy === 1'b1 && guard < 30) begin
            @(posedge clk); #1; guard++;
        end
        chk({nm, " idle_before"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b; bus.rd_in = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom);
        bus.op = 2'($urandom); bus.rd_in = 3'($urandom);
        lat = 1; seen = 1'b0; bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (bus.wr_en !== 1'b0 || bus.busy !== 1'b1) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, " done_seen"}, 32'(seen), 32'd1);
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " run_quiet"}, 32'(bad), 32'd0);
        chk({nm, " busy_in_done"}, 32'(bus.busy), 32'd1);
        chk({nm, " wr_en"}, 32'(bus.wr_en), 32'(rd != 3'd0));
        chk({nm, " wr_rd"}, 32'(bus.wr_rd), 32'(rd));
        chk({nm, " wr_data"}, 32'(bus.wr_data), 32'(exp_data));
        @(posedge clk); #1;
        chk({nm, " done_pulse_one"}, 32'(bus.done), 32'd0);
        chk({nm, " wr_en_drop"}, 32'(bus.wr_en), 32'd0);
        chk({nm, " idle_after"}, 32'(bus.busy), 32'd0);
        chk({nm, " wr_data_hold"}, 32'(bus.wr_data), 32'(exp_data));
    endtask

    initial begin
        int prev, npulse, first, bad_gap, bad_data, wr_seen, stray;

        // Normal ops take W RUN cycles + the accept edge: done visible after edge W+1.
        add("mul_13x11",   2'b00, 8'd13,  8'd11,  3'd3, 8'h8F, W + 1);
        add("mulh_13x11",  2'b01, 8'd13,  8'd11,  3'd3, 8'h00, W + 1);
        add("mul_200x200", 2'b00, 8'd200, 8'd200, 3'd1, 8'h40, W + 1);
        add("mulh_200x200",2'b01, 8'd200, 8'd200, 3'd7, 8'h9C, W + 1);
        add("mul_ffxff",   2'b00, 8'hFF,  8'hFF,  3'd6, 8'h01, W + 1);
        add("mulh_ffxff",  2'b01, 8'hFF,  8'hFF,  3'd6, 8'hFE, W + 1);
        add("mul_by_zero", 2'b00, 8'h37,  8'h00,  3'd2, 8'h00, W + 1);
        add("mul_rd0",     2'b00, 8'd13,  8'd11,  3'd0, 8'h8F, W + 1);
        if (DIV_EN) begin
            add("divu_100_7", 2'b10, 8'd100, 8'd7, 3'd5, 8'd14,  W + 1);
            add("remu_100_7", 2'b11, 8'd100, 8'd7, 3'd5, 8'd2,   W + 1);
            add("divu_5_9",   2'b10, 8'd5,   8'd9, 3'd4, 8'd0,   W + 1);
            add("remu_5_9",   2'b11, 8'd5,   8'd9, 3'd4, 8'd5,   W + 1);
            add("divu_by0",   2'b10, 8'h2A,  8'h0, 3'd2, 8'hFF,  1);
            add("remu_by0",   2'b11, 8'h2A,  8'h0, 3'd2, 8'h2A,  1);
            add("divu_ff_1",  2'b10, 8'hFF,  8'h1, 3'd1, 8'hFF,  W + 1);
            add("remu_by0_r0",2'b11, 8'h00,  8'h0, 3'd0, 8'h00,  1);
        end else begin
            add("divu_100_7", 2'b10, 8'd100, 8'd7, 3'd5, 8'h00, 1);
            add("remu_100_7", 2'b11, 8'd100, 8'd7, 3'd5, 8'h00, 1);
            add("divu_by0",   2'b10, 8'h2A,  8'h0, 3'd2, 8'h00, 1);
            add("remu_r0",    2'b11, 8'h55,  8'h3, 3'd0, 8'h00, 1);
        end

        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0; bus.rd_in = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",    32'(bus.busy),    32'd0);
        chk("reset done",    32'(bus.done),    32'd0);
        chk("reset wr_en",   32'(bus.wr_en),   32'd0);
        chk("reset wr_rd",   32'(bus.wr_rd),   32'd0);
        chk("reset wr_data", 32'(bus.wr_data), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle no start", 32'(bus.busy), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp_data, vecs[i].exp_lat);
        end

        // Reset during the 4th RUN cycle drops the op with no write.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'd9; bus.b = 8'd9; bus.rd_in = 3'd4;
        @(posedge clk); #1;           // accept; RUN cycle 1
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end   // RUN cycle 4
        chk("mid busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid busy",    32'(bus.busy),    32'd0);
        chk("rst_mid done",    32'(bus.done),    32'd0);
        chk("rst_mid wr_data", 32'(bus.wr_data), 32'd0);
        stray = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.wr_en !== 1'b0 || bus.busy !== 1'b0) stray++;
        end
        chk("rst_mid no_write", 32'(stray), 32'd0);
        run_op("mul_after_rst", 2'b00, 8'd3, 8'd4, 3'd1, 8'd12, W + 1);

        // start held high with rd=0: a pulse every W+2 edges, never a write.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.a = 8'd5; bus.b = 8'd6; bus.rd_in = 3'd0;
        prev = -1; npulse = 0; first = -1; bad_gap = 0; bad_data = 0; wr_seen = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.wr_en !== 1'b0) wr_seen++;
            if (bus.done === 1'b1) begin
                if (first < 0) first = c;
                if (prev >= 0 && (c - prev) != W + 2) bad_gap++;
                if (bus.wr_data !== 8'd30) bad_data++;
                prev = c;
                npulse++;
            end
        end
        bus.start = 1'b0;
        chk("b2b first_done", 32'(first),    32'(W + 1));
        chk("b2b pulses",     32'(npulse),   32'd4);
        chk("b2b gap",        32'(bad_gap),  32'd0);
        chk("b2b data",       32'(bad_data), 32'd0);
        chk("b2b wr_en",      32'(wr_seen),  32'd0);

        run_op("final_mulh", 2'b01, 8'hF0, 8'h10, 3'd7, 8'h0F, W + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
